dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Byte-addressed, word-organised data memory with RV32I load/store sizing, sign/zero extension and alignment/range checking.
- Requests use a valid/ready handshake with a parametrised fixed access latency, so the memory can move from the single-cycle core to multi-cycle and pipelined cores.
- Sits between the core's execute/memory stage and the data RAM.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- DEPTH, 64, number of XLEN-bit words; must be a power of two; the byte address space is 0 .. DEPTH*4-1.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..8.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 size/sign code
- req_address  input  XLEN  byte address
- req_write_data  input  XLEN  store data; the low bytes are used per size
- resp_valid  output  1  one-cycle response strobe
- resp_read_data  output  XLEN  extended load data; 0 for stores and errors
- resp_error  output  1  request was misaligned, out of range or had an illegal funct3; qualified by resp_valid

Behaviour:
- Reset (async, any time):
  - FSM goes to IDLE; all memory words become 0.
  - req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0.
  - An in-flight request is dropped: no write, no response.
- Acceptance:
  - A request is accepted at a rising edge where req_valid && req_ready. Call that edge E1.
  - At E1, req_write, req_funct3, req_address and req_write_data are captured. Later changes to the inputs are ignored.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, on acceptance: go to RESP if LATENCY=1; otherwise go to WAIT with counter=LATENCY-2.
  - WAIT: the counter decrements each edge. At counter==0 the next edge goes to RESP.
  - RESP: resp_valid=1 for exactly this cycle. If a new request is accepted at the end of RESP, apply the IDLE acceptance rule; otherwise go to IDLE.
  - req_ready=1 in IDLE and RESP, 0 in WAIT. With LATENCY=1 this gives back-to-back throughput of one request per cycle.
- Timing and commit:
  - The response is visible in the cycle after edge E_LATENCY, where E_k is the k-th edge counting the acceptance edge as E1.
  - A store commits to memory at edge E_LATENCY.
  - A load reads memory at edge E_LATENCY, so it sees every store that committed before it.
- Addressing and endianness:
  - Word index = address[log2(DEPTH)+1:2]; byte lane = address[1:0]; little-endian.
- Error conditions (resp_error=1):
  - address >= DEPTH*4.
  - funct3=001 with address[0]=1.
  - funct3=010 with address[1:0]!=0.
  - Loads with funct3 in {011,110,111}.
  - Stores with funct3 not in {000,001,010}.
  - On error: no write, resp_read_data=0.
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected half-word.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
- Stores:
  - SB writes only the addressed byte lane; SH writes lanes {1,0} or {3,2}; SW writes all four lanes. Other lanes are unchanged.
  - resp_read_data=0 on a successful store.
- Outputs are registered. Outside RESP, resp_read_data and resp_error hold 0.

Test Plan:
- Reset then LW at 0x00 (LATENCY=1) -> resp_valid one cycle after acceptance; data 0x00000000; error 0.
- SW 0x8899AABB @0x10, then SB 0x11 @0x12, then LW @0x10 -> 0x8811AABB.
- Using that word: LB @0x13 -> 0xFFFFFF88; LBU @0x13 -> 0x00000088; LH @0x12 -> 0xFFFF8811; LHU @0x10 -> 0x0000AABB.
- Each of the following -> resp_error=1, data 0, memory unchanged on read-back:
  - LW @0x11.
  - SH @0x13.
  - LW @0x100 (DEPTH=64).
  - Load with funct3=011.
- LATENCY=3:
  - req_ready=0 for 2 cycles after acceptance; resp_valid in the 3rd cycle.
  - A new request held on req_valid is accepted in the RESP cycle.
  - Inputs changed during WAIT do not affect the result.
- LATENCY=3, SW 0xDEADBEEF @0x20, assert reset during WAIT -> no response. Then LW @0x20 -> 0x00000000.

Source files
------------

// File: rtl/dmem_lsu.sv
// Byte-addressed RV32I data memory with a valid/ready request port, fixed access
// latency, sign/zero extended loads, lane-masked stores and alignment/range checks.
module dmem_lsu #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_address,
  input  logic [XLEN-1:0] req_write_data,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_read_data,
  output logic            resp_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 3;
  localparam logic [CW-1:0] WAIT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            accept, commit;

  logic            cap_write;
  logic [2:0]      cap_funct3;
  logic [XLEN-1:0] cap_address, cap_write_data;

  logic            op_write;
  logic [2:0]      op_funct3;
  logic [XLEN-1:0] op_address, op_write_data;

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            err;
  logic [XLEN-1:0] shifted, load_data, store_data;
  logic [3:0]      store_mask;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        req_ready  = 1'b1;
        resp_valid = (state_q == RESP);
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            count_d = WAIT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (count_q == '0) state_d = RESP;
        else               count_d = count_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // With single-cycle latency the access happens on the acceptance edge itself,
  // so the live inputs are used instead of the captured copy.
  assign commit        = (LATENCY == 1) ? accept : (state_q == WAIT && count_q == '0);
  assign op_write      = (LATENCY == 1) ? req_write      : cap_write;
  assign op_funct3     = (LATENCY == 1) ? req_funct3     : cap_funct3;
  assign op_address    = (LATENCY == 1) ? req_address    : cap_address;
  assign op_write_data = (LATENCY == 1) ? req_write_data : cap_write_data;

  always_comb begin
    idx     = op_address[AW+1:2];
    lane    = op_address[1:0];
    err     = 1'b0;
    if (|op_address[XLEN-1:AW+2])                 err = 1'b1;
    if (op_funct3[1:0] == 2'b01 && lane[0])       err = 1'b1;
    if (op_funct3[1:0] == 2'b10 && lane != 2'b00) err = 1'b1;
    if (op_write) begin
      if (!(op_funct3 inside {3'b000, 3'b001, 3'b010})) err = 1'b1;
    end else begin
      if (op_funct3 inside {3'b011, 3'b110, 3'b111}) err = 1'b1;
    end

    shifted = mem[idx] >> {lane, 3'b000};
    case (op_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b101:  load_data = {16'b0, shifted[15:0]};
      default: load_data = '0;
    endcase

    case (op_funct3[1:0])
      2'b00: begin
        store_data = {4{op_write_data[7:0]}};
        store_mask = 4'b0001 << lane;
      end
      2'b01: begin
        store_data = {2{op_write_data[15:0]}};
        store_mask = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = op_write_data;
        store_mask = 4'b1111;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      cap_write      <= 1'b0;
      cap_funct3     <= '0;
      cap_address    <= '0;
      cap_write_data <= '0;
      resp_read_data <= '0;
      resp_error     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        cap_write      <= req_write;
        cap_funct3     <= req_funct3;
        cap_address    <= req_address;
        cap_write_data <= req_write_data;
      end
      resp_read_data <= (commit && !op_write && !err) ? load_data : '0;
      resp_error     <= commit && err;
    end
  end

  // NOTE: the array is built from flops rather than a RAM macro because the
  // whole memory must clear on the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else if (commit && op_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (store_mask[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: one instance at LATENCY=1, one at LATENCY=3,
// with a per-instance expected-response queue drained by a negedge monitor.
module tb_dmem_lsu;

  logic        clock;
  logic        reset          [2];
  logic        req_valid      [2];
  logic        req_ready      [2];
  logic        req_write      [2];
  logic [2:0]  req_funct3     [2];
  logic [31:0] req_address    [2];
  logic [31:0] req_write_data [2];
  logic        resp_valid     [2];
  logic [31:0] resp_read_data [2];
  logic        resp_error     [2];

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   total = 0;
  int   bad   = 0;

  dmem_lsu #(.XLEN(32), .DEPTH(64), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_funct3(req_funct3[0]), .req_address(req_address[0]),
    .req_write_data(req_write_data[0]), .resp_valid(resp_valid[0]),
    .resp_read_data(resp_read_data[0]), .resp_error(resp_error[0])
  );

  dmem_lsu #(.XLEN(32), .DEPTH(64), .LATENCY(3)) dut3 (
    .clock(clock), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_funct3(req_funct3[1]), .req_address(req_address[1]),
    .req_write_data(req_write_data[1]), .resp_valid(resp_valid[1]),
    .resp_read_data(resp_read_data[1]), .resp_error(resp_error[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] data, input logic err, input string tag);
    exp_t e;
    e.data = data;
    e.err  = err;
    e.tag  = tag;
    if (s == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  function automatic int sb_size(input int s);
    return (s == 0) ? sb0.size() : sb1.size();
  endfunction

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic issue(input int s, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_err, input string tag);
    int n = 0;
    req_valid[s]      = 1'b1;
    req_write[s]      = wr;
    req_funct3[s]     = f3;
    req_address[s]    = addr;
    req_write_data[s] = wd;
    while (req_ready[s] !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_accept"}, {31'b0, req_ready[s]}, 32'd1);
    push(s, exp_data, exp_err, tag);
    @(posedge clock);
    @(negedge clock);
    req_valid[s] = 1'b0;
  endtask

  task automatic drain(input int s);
    int n = 0;
    while (sb_size(s) != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("drain%0d", s), 32'(sb_size(s)), 32'd0);
  endtask

  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (reset[s] !== 1'b0) continue;
      if (resp_valid[s] === 1'b1) begin
        if (sb_size(s) == 0) begin
          check($sformatf("unexpected_resp%0d", s), {31'b0, resp_valid[s]}, 32'd0);
        end else begin
          exp_t e;
          if (s == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          check({e.tag, "_data"}, resp_read_data[s], e.data);
          check({e.tag, "_err"}, {31'b0, resp_error[s]}, {31'b0, e.err});
        end
      end else begin
        check($sformatf("idle_data%0d", s), resp_read_data[s], 32'd0);
        check($sformatf("idle_err%0d", s), {31'b0, resp_error[s]}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      reset[s]          = 1'b1;
      req_valid[s]      = 1'b0;
      req_write[s]      = 1'b0;
      req_funct3[s]     = 3'b000;
      req_address[s]    = '0;
      req_write_data[s] = '0;
    end
    repeat (2) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_ready%0d", s), {31'b0, req_ready[s]}, 32'd1);
      check($sformatf("rst_valid%0d", s), {31'b0, resp_valid[s]}, 32'd0);
      check($sformatf("rst_data%0d", s), resp_read_data[s], 32'd0);
      check($sformatf("rst_err%0d", s), {31'b0, resp_error[s]}, 32'd0);
      reset[s] = 1'b0;
    end
    @(negedge clock);

    // LATENCY=1: back-to-back requests, sizing, extension and error cases.
    issue(0, 0, 3'b010, 32'h00, 32'h0, 32'h0, 0, "lw_0_after_reset");
    check("lat1_resp_next_cycle", {31'b0, resp_valid[0]}, 32'd1);
    issue(0, 1, 3'b010, 32'h10, 32'h8899AABB, 32'h0, 0, "sw_10");
    issue(0, 1, 3'b000, 32'h12, 32'hFFFFFF11, 32'h0, 0, "sb_12");
    issue(0, 0, 3'b010, 32'h10, 32'h0, 32'h8811AABB, 0, "lw_10");
    issue(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 0, "lb_13");
    issue(0, 0, 3'b100, 32'h13, 32'h0, 32'h00000088, 0, "lbu_13");
    issue(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF8811, 0, "lh_12");
    issue(0, 0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 0, "lhu_10");
    issue(0, 0, 3'b010, 32'h11, 32'h0, 32'h0, 1, "lw_misaligned");
    issue(0, 1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0, 1, "sh_misaligned");
    issue(0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 1, "lw_out_of_range");
    issue(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "load_f3_011");
    issue(0, 0, 3'b110, 32'h10, 32'h0, 32'h0, 1, "load_f3_110");
    issue(0, 0, 3'b111, 32'h10, 32'h0, 32'h0, 1, "load_f3_111");
    issue(0, 1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1, "store_f3_011");
    issue(0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1, "store_f3_100");
    issue(0, 1, 3'b010, 32'h110, 32'h0, 32'h0, 1, "sw_out_of_range");
    issue(0, 0, 3'b010, 32'h10, 32'h0, 32'h8811AABB, 0, "lw_10_unchanged");
    issue(0, 1, 3'b001, 32'h16, 32'h1234CAFE, 32'h0, 0, "sh_16");
    issue(0, 0, 3'b010, 32'h14, 32'h0, 32'hCAFE0000, 0, "lw_14");
    issue(0, 0, 3'b001, 32'h16, 32'h0, 32'hFFFFCAFE, 0, "lh_16");
    issue(0, 0, 3'b101, 32'h16, 32'h0, 32'h0000CAFE, 0, "lhu_16");
    issue(0, 1, 3'b010, 32'hFC, 32'h01020304, 32'h0, 0, "sw_last");
    issue(0, 0, 3'b010, 32'hFC, 32'h0, 32'h01020304, 0, "lw_last");
    issue(0, 0, 3'b000, 32'hFF, 32'h0, 32'h00000001, 0, "lb_last");
    issue(0, 0, 3'b001, 32'hFE, 32'h0, 32'h00000102, 0, "lh_last");
    drain(0);

    // LATENCY=3: ready timing, held request accepted in RESP, WAIT inputs ignored.
    issue(1, 1, 3'b010, 32'h20, 32'h12345678, 32'h0, 0, "l3_sw_20");
    drain(1);
    req_valid[1]      = 1'b1;
    req_write[1]      = 1'b0;
    req_funct3[1]     = 3'b010;
    req_address[1]    = 32'h20;
    req_write_data[1] = 32'h0;
    check("l3_a_ready", {31'b0, req_ready[1]}, 32'd1);
    push(1, 32'h12345678, 0, "l3_lw_20");
    @(posedge clock);
    @(negedge clock);
    check("l3_wait1_ready", {31'b0, req_ready[1]}, 32'd0);
    check("l3_wait1_valid", {31'b0, resp_valid[1]}, 32'd0);
    req_write[1]      = 1'b1;
    req_funct3[1]     = 3'b100;
    req_address[1]    = 32'h23;
    req_write_data[1] = 32'hFFFFFFFF;
    @(negedge clock);
    check("l3_wait2_ready", {31'b0, req_ready[1]}, 32'd0);
    check("l3_wait2_valid", {31'b0, resp_valid[1]}, 32'd0);
    req_write[1] = 1'b0;
    @(negedge clock);
    check("l3_resp_valid", {31'b0, resp_valid[1]}, 32'd1);
    check("l3_resp_ready", {31'b0, req_ready[1]}, 32'd1);
    push(1, 32'h00000012, 0, "l3_held_lbu_23");
    @(posedge clock);
    @(negedge clock);
    req_valid[1] = 1'b0;
    check("l3_held_accepted", {31'b0, req_ready[1]}, 32'd0);
    drain(1);
    issue(1, 0, 3'b010, 32'h20, 32'h0, 32'h12345678, 0, "l3_lw_20_again");
    drain(1);

    // LATENCY=3: reset during WAIT drops the store and clears memory.
    req_valid[1]      = 1'b1;
    req_write[1]      = 1'b1;
    req_funct3[1]     = 3'b010;
    req_address[1]    = 32'h20;
    req_write_data[1] = 32'hDEADBEEF;
    check("rstw_ready", {31'b0, req_ready[1]}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid[1] = 1'b0;
    check("rstw_in_wait", {31'b0, req_ready[1]}, 32'd0);
    reset[1] = 1'b1;
    #1;
    check("rstw_ready_async", {31'b0, req_ready[1]}, 32'd1);
    check("rstw_valid_async", {31'b0, resp_valid[1]}, 32'd0);
    @(negedge clock);
    reset[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("rstw_no_resp", {31'b0, resp_valid[1]}, 32'd0);
    end
    issue(1, 0, 3'b010, 32'h20, 32'h0, 32'h00000000, 0, "l3_lw_20_after_reset");
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
